alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
// - Parametrised multi-cycle ALU; successor to the combinational 32-bit ALU.
// - Keeps the same 6-bit func encoding. Adds WIDTH, iterative mul/div (full hi/lo result),
//   status flags and valid/ready handshakes on both sides.
// - Sits in EX between operand-forward mux and EX/MEM stage; stalls the pipe via in_ready.
// PARAMETERS
// - WIDTH   32  operand/result width; power of 2, >=8
// - SHAMT_W  5  shift-amount bits = log2(WIDTH); set consistently with WIDTH
// PORTS
// - clk          in   1      clock, all logic rising-edge
// - rst          in   1      synchronous reset, active-high
// - in_valid     in   1      op_0/op_1/func valid
// - in_ready     out  1      ALU accepts a new op (IDLE only)
// - func         in   6      opcode (below)
// - op_0         in   WIDTH  operand A / dividend / value to shift
// - op_1         in   WIDTH  operand B / divisor / shift amount (low SHAMT_W bits)
// - out_valid    out  1      result_lo/result_hi/flags valid
// - out_ready    in   1      consumer takes result
// - result_lo    out  WIDTH  result; product low; quotient
// - result_hi    out  WIDTH  product high; remainder; else 0
// - ovf          out  1      signed add/sub overflow, or signed div MIN/-1
// - div_zero     out  1      divide with op_1==0
// - illegal      out  1      undefined func
// BEHAVIOUR
// - Interface: one clock, synchronous active-high reset.
// - func: 00 add, 01 addu, 02 sub, 03 subu, 04 mul, 05 mulu, 06 div, 07 divu, 08 and, 09 or,
//   10 xor, 11 nor, 12 sll, 13 sra, 14 srl (hex). Any other code is illegal.
// - Reset: state IDLE, in_ready=1, out_valid=0, result_lo=result_hi=0, all flags 0.
//   Reset mid-operation aborts; no result is produced.
// - FSM IDLE->EXEC->DONE->IDLE:
//   - IDLE: accept when in_valid&&in_ready; latch func/operands.
//     Single-cycle op -> DONE. mul/div -> EXEC.
//   - EXEC: WIDTH iterations, one per cycle (radix-2 shift-add mul; restoring div on magnitudes),
//     then DONE.
//   - DONE: out_valid=1 with outputs held stable until out_ready; then IDLE.
//   - in_ready=1 only in IDLE; no overlap of ops.
// - Latency, accept edge = cycle N:
//   - single-cycle ops: out_valid at N+1.
//   - mul/div: out_valid at N+1+WIDTH; div_zero and MIN/-1 cases also take full latency.
// - Throughput: one op per 2 cycles (single-cycle op, out_ready tied 1).
// - Arithmetic: all results wrap modulo 2^WIDTH.
//   - ovf on add/sub = signed overflow. addu/subu never set ovf.
//   - mul: signed/unsigned 2*WIDTH product, {result_hi,result_lo}.
//   - div: quotient truncates toward zero; remainder takes dividend sign.
//   - op_1==0: result_lo=all ones, result_hi=op_0, div_zero=1.
//   - div MIN/-1: result_lo=MIN, result_hi=0, ovf=1.
//   - shifts use op_1[SHAMT_W-1:0]; upper bits ignored; sra sign-fills; shift 0 = op_0.
//   - Non-mul/div ops: result_hi=0.
// - Illegal func: result_lo=result_hi=0, illegal=1, single-cycle latency.
// - Flags are valid only with out_valid and are cleared on the IDLE transition.
// - in_valid while busy is ignored, not queued; the producer must hold until in_ready.
// TESTING
// - T1 add 7FFFFFFF+1, out_ready=1 -> N+1: result_lo=80000000, ovf=1; addu same -> ovf=0.
// - T2 mul FFFFFFFF*2 -> N+33: lo=FFFFFFFE, hi=FFFFFFFF; mulu same -> hi=00000001.
// - T3 div -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF;
//      divu 7/0 -> lo=FFFFFFFF, hi=7, div_zero=1; div 80000000/FFFFFFFF -> lo=80000000, ovf=1.
// - T4 sra 80000000 by op_1=0x24 (shamt 4) -> F8000000; srl -> 08000000; sll 1 by 31 -> 80000000.
// - T5 mul accepted, out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0;
//      in_valid pulses during EXEC ignored.
// - T6 rst asserted at EXEC cycle 10 -> next cycle out_valid=0, in_ready=1, outputs 0;
//      func 3F -> illegal=1.

Source files
------------

// File: rtl/alu_mc_if.sv
// Handshake and data bundle between an EX-stage producer/consumer and the multi-cycle ALU.
// The master side drives operands and out_ready; the slave side (the ALU) drives results.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       func;
    logic [WIDTH-1:0] op_0;
    logic [WIDTH-1:0] op_1;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             ovf;
    logic             div_zero;
    logic             illegal;

    modport master (
        output in_valid,
        output func,
        output op_0,
        output op_1,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result_lo,
        input  result_hi,
        input  ovf,
        input  div_zero,
        input  illegal
    );

    modport slave (
        input  in_valid,
        input  func,
        input  op_0,
        input  op_1,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result_lo,
        output result_hi,
        output ovf,
        output div_zero,
        output illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic/shift ops, iterative radix-2 multiply and
// restoring divide on magnitudes, with valid/ready handshakes on both sides.
module alu_mc #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input logic     clk,
    input logic     rst,
    alu_mc_if.slave bus
);
    localparam logic [5:0] FnAdd  = 6'h00;
    localparam logic [5:0] FnAddu = 6'h01;
    localparam logic [5:0] FnSub  = 6'h02;
    localparam logic [5:0] FnSubu = 6'h03;
    localparam logic [5:0] FnMul  = 6'h04;
    localparam logic [5:0] FnMulu = 6'h05;
    localparam logic [5:0] FnDiv  = 6'h06;
    localparam logic [5:0] FnDivu = 6'h07;
    localparam logic [5:0] FnAnd  = 6'h08;
    localparam logic [5:0] FnOr   = 6'h09;
    localparam logic [5:0] FnXor  = 6'h0A;
    localparam logic [5:0] FnNor  = 6'h0B;
    localparam logic [5:0] FnSll  = 6'h0C;
    localparam logic [5:0] FnSra  = 6'h0D;
    localparam logic [5:0] FnSrl  = 6'h0E;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         func_q, func_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   work_hi_q, work_hi_d;
    logic [WIDTH-1:0]   work_lo_q, work_lo_d;
    logic [WIDTH-1:0]   op0_q, op0_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic               ill_q, ill_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;

    // Single-cycle datapath, evaluated directly on the bus inputs while idle.
    logic [WIDTH-1:0]   add_sum, sub_dif, sc_lo;
    logic               sc_ovf, sc_ill;
    logic [SHAMT_W-1:0] shamt;

    assign add_sum = bus.op_0 + bus.op_1;
    assign sub_dif = bus.op_0 - bus.op_1;
    assign shamt   = bus.op_1[SHAMT_W-1:0];

    always_comb begin
        sc_lo  = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (bus.func)
            FnAdd: begin
                sc_lo  = add_sum;
                sc_ovf = (bus.op_0[WIDTH-1] == bus.op_1[WIDTH-1]) &&
                         (add_sum[WIDTH-1] != bus.op_0[WIDTH-1]);
            end
            FnAddu: sc_lo = add_sum;
            FnSub: begin
                sc_lo  = sub_dif;
                sc_ovf = (bus.op_0[WIDTH-1] != bus.op_1[WIDTH-1]) &&
                         (sub_dif[WIDTH-1] != bus.op_0[WIDTH-1]);
            end
            FnSubu: sc_lo = sub_dif;
            FnAnd:  sc_lo = bus.op_0 & bus.op_1;
            FnOr:   sc_lo = bus.op_0 | bus.op_1;
            FnXor:  sc_lo = bus.op_0 ^ bus.op_1;
            FnNor:  sc_lo = ~(bus.op_0 | bus.op_1);
            FnSll:  sc_lo = bus.op_0 << shamt;
            FnSra:  sc_lo = $unsigned($signed(bus.op_0) >>> shamt);
            FnSrl:  sc_lo = bus.op_0 >> shamt;
            FnMul, FnMulu, FnDiv, FnDivu: sc_lo = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // Operand decode for the iterative units: signed variants work on magnitudes.
    logic             in_mul, in_div, in_signed, sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign in_mul    = (bus.func == FnMul) || (bus.func == FnMulu);
    assign in_div    = (bus.func == FnDiv) || (bus.func == FnDivu);
    assign in_signed = (bus.func == FnMul) || (bus.func == FnDiv);
    assign sgn_a     = in_signed && bus.op_0[WIDTH-1];
    assign sgn_b     = in_signed && bus.op_1[WIDTH-1];
    assign mag_a     = sgn_a ? -bus.op_0 : bus.op_0;
    assign mag_b     = sgn_b ? -bus.op_1 : bus.op_1;

    // One shift-add multiply step: {work_hi, work_lo} holds {partial, multiplier}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
    logic [2*WIDTH-1:0] prod, prod_fix;

    assign mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    assign prod      = {mul_hi_nx, mul_lo_nx};
    assign prod_fix  = neg_lo_q ? -prod : prod;

    // One restoring divide step: {work_hi, work_lo} holds {remainder, dividend/quotient}.
    logic [WIDTH:0]   div_sh, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx, quo_fix, rem_fix;

    assign div_sh    = {work_hi_q, work_lo_q[WIDTH-1]};
    assign div_sub   = div_sh - {1'b0, opb_q};
    assign div_ge    = div_sh >= {1'b0, opb_q};
    assign div_hi_nx = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo_nx = {work_lo_q[WIDTH-2:0], div_ge};
    assign quo_fix   = dz_q ? '1 : (neg_lo_q ? -div_lo_nx : div_lo_nx);
    assign rem_fix   = dz_q ? op0_q : (neg_hi_q ? -div_hi_nx : div_hi_nx);

    logic exec_mul, last_iter;

    assign exec_mul  = (func_q == FnMul) || (func_q == FnMulu);
    assign last_iter = (cnt_q == SHAMT_W'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        func_d    = func_q;
        opb_d     = opb_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        op0_d     = op0_q;
        cnt_d     = cnt_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        ill_d     = ill_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    func_d = bus.func;
                    if (in_mul || in_div) begin
                        state_d   = StExec;
                        cnt_d     = '0;
                        work_hi_d = '0;
                        work_lo_d = mag_a;
                        opb_d     = mag_b;
                        op0_d     = bus.op_0;
                        neg_lo_d  = sgn_a ^ sgn_b;
                        neg_hi_d  = sgn_a;
                        dz_d      = in_div && (bus.op_1 == '0);
                        ovf_d     = (bus.func == FnDiv) && (bus.op_0 == MinVal) &&
                                    (bus.op_1 == '1);
                        ill_d     = 1'b0;
                    end else begin
                        state_d  = StDone;
                        res_lo_d = sc_lo;
                        res_hi_d = '0;
                        ovf_d    = sc_ovf;
                        ill_d    = sc_ill;
                        dz_d     = 1'b0;
                    end
                end
            end
            StExec: begin
                cnt_d     = cnt_q + SHAMT_W'(1);
                work_hi_d = exec_mul ? mul_hi_nx : div_hi_nx;
                work_lo_d = exec_mul ? mul_lo_nx : div_lo_nx;
                if (last_iter) begin
                    state_d  = StDone;
                    res_lo_d = exec_mul ? prod_fix[WIDTH-1:0] : quo_fix;
                    res_hi_d = exec_mul ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d  = StIdle;
                    res_lo_d = '0;
                    res_hi_d = '0;
                    ovf_d    = 1'b0;
                    dz_d     = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            func_q    <= '0;
            opb_q     <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            op0_q     <= '0;
            cnt_q     <= '0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            ill_q     <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
        end else begin
            state_q   <= state_d;
            func_q    <= func_d;
            opb_q     <= opb_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            op0_q     <= op0_d;
            cnt_q     <= cnt_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            ill_q     <= ill_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
        end
    end

    // Division flags are captured at accept; only expose them alongside the result.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.ovf       = ovf_q && (state_q == StDone);
    assign bus.div_zero  = dz_q && (state_q == StDone);
    assign bus.illegal   = ill_q && (state_q == StDone);
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: expected results are modelled with native operators,
// queued at accept and compared when the ALU presents its result.
module tb_alu_mc;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(
        .WIDTH  (W),
        .SHAMT_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         ovf;
        logic         dz;
        logic         ill;
        logic [7:0]   lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        exp_t             e;
        logic [W:0]       s;
        logic [2*W-1:0]   p;
        logic [4:0]       sh;
        logic [W-1:0]     min_v;
        e     = '0;
        e.lat = 8'd1;
        sh    = b[4:0];
        min_v = {1'b1, {(W-1){1'b0}}};
        case (f)
            6'h00: begin s = {a[W-1], a} + {b[W-1], b}; e.lo = s[W-1:0]; e.ovf = s[W] ^ s[W-1]; end
            6'h01: e.lo = a + b;
            6'h02: begin s = {a[W-1], a} - {b[W-1], b}; e.lo = s[W-1:0]; e.ovf = s[W] ^ s[W-1]; end
            6'h03: e.lo = a - b;
            6'h04: begin
                p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = 8'(W + 1);
            end
            6'h05: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.lo = p[W-1:0]; e.hi = p[2*W-1:W]; e.lat = 8'(W + 1);
            end
            6'h06: begin
                e.lat = 8'(W + 1);
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (a == min_v && b == '1) begin
                    e.lo = min_v; e.hi = '0; e.ovf = 1'b1;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
            6'h07: begin
                e.lat = 8'(W + 1);
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else begin
                    e.lo = a / b; e.hi = a % b;
                end
            end
            6'h08: e.lo = a & b;
            6'h09: e.lo = a | b;
            6'h0A: e.lo = a ^ b;
            6'h0B: e.lo = ~(a | b);
            6'h0C: e.lo = a << sh;
            6'h0D: e.lo = $signed(a) >>> sh;
            6'h0E: e.lo = a >> sh;
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Issue one op, optionally stall the consumer for hold cycles and pulse in_valid while busy.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input bit pulse);
        exp_t         e;
        int           lat;
        logic [W-1:0] lo0, hi0;
        bus.func     = f;
        bus.op_0     = a;
        bus.op_1     = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50 && !bus.in_ready; i++) begin
            @(posedge clk); #1;
        end
        check_val("in_ready_idle", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        sb_q.push_back(model(f, a, b));
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = (hold == 0);
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            if (pulse) begin
                check_val("in_ready_busy", 64'(bus.in_ready), 64'd0);
                bus.in_valid = (lat % 3 == 0);
                bus.func     = 6'h00;
                bus.op_0     = $urandom;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check_val("out_valid", 64'(bus.out_valid), 64'd1);
        lo0 = bus.result_lo;
        hi0 = bus.result_hi;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_lo", 64'(bus.result_lo), 64'(lo0));
            check_val("hold_hi", 64'(bus.result_hi), 64'(hi0));
            check_val("hold_valid", 64'(bus.out_valid), 64'd1);
            check_val("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        check_val("sb_size", 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val($sformatf("lo_f%0h", f), 64'(bus.result_lo), 64'(e.lo));
            check_val($sformatf("hi_f%0h", f), 64'(bus.result_hi), 64'(e.hi));
            check_val($sformatf("ovf_f%0h", f), 64'(bus.ovf), 64'(e.ovf));
            check_val($sformatf("dz_f%0h", f), 64'(bus.div_zero), 64'(e.dz));
            check_val($sformatf("ill_f%0h", f), 64'(bus.illegal), 64'(e.ill));
            check_val($sformatf("lat_f%0h", f), 64'(lat), 64'(e.lat));
        end
        @(posedge clk); #1;
        check_val("post_valid", 64'(bus.out_valid), 64'd0);
        check_val("post_in_ready", 64'(bus.in_ready), 64'd1);
        check_val("post_flags", 64'({bus.ovf, bus.div_zero, bus.illegal}), 64'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check_val({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check_val({tag, "_lo"}, 64'(bus.result_lo), 64'd0);
        check_val({tag, "_hi"}, 64'(bus.result_hi), 64'd0);
        check_val({tag, "_flags"}, 64'({bus.ovf, bus.div_zero, bus.illegal}), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        logic [5:0] rf;
        logic [W-1:0] ra, rb;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.func      = '0;
        bus.op_0      = '0;
        bus.op_1      = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        do_op(6'h00, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);
        do_op(6'h01, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1'b0);
        do_op(6'h02, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
        do_op(6'h03, 32'h8000_0000, 32'h0000_0001, 0, 1'b0);
        do_op(6'h04, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
        do_op(6'h05, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1'b0);
        do_op(6'h06, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
        do_op(6'h07, 32'h0000_0007, 32'h0000_0000, 0, 1'b0);
        do_op(6'h06, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(6'h06, 32'hFFFF_FFF9, 32'h0000_0000, 0, 1'b0);
        do_op(6'h0D, 32'h8000_0000, 32'h0000_0024, 0, 1'b0);
        do_op(6'h0E, 32'h8000_0000, 32'h0000_0024, 0, 1'b0);
        do_op(6'h0C, 32'h0000_0001, 32'h0000_001F, 0, 1'b0);
        do_op(6'h0C, 32'h1234_5678, 32'hFFFF_FFE0, 0, 1'b0);
        do_op(6'h08, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
        do_op(6'h09, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
        do_op(6'h0A, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
        do_op(6'h0B, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 1'b0);
        do_op(6'h04, 32'h8000_0000, 32'h8000_0000, 5, 1'b1);
        do_op(6'h07, 32'hDEAD_BEEF, 32'h0000_1234, 3, 1'b1);

        // Abort a multiply mid-iteration; no result may appear afterwards.
        bus.func     = 6'h05;
        bus.op_0     = 32'h1234_5678;
        bus.op_1     = 32'h9ABC_DEF0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_state("abort");
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check_val("abort_no_result", 64'(seen), 64'd0);

        do_op(6'h3F, 32'h1111_2222, 32'h3333_4444, 0, 1'b0);
        do_op(6'h0F, 32'h1111_2222, 32'h3333_4444, 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            rf = 6'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            if ($urandom_range(0, 3) == 0) rb = -rb;
            do_op(rf, ra, rb, $urandom_range(0, 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
